// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised input, 3-sample majority vote per bit,
// run-time parity/stop selection, parity/framing/break reporting.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 sample_tick,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [PW-1:0] PH_ONE  = PW'(1);
  localparam logic [PW-1:0] PH_A    = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_B    = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_DEC  = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } state_e;

  // Kept as a named register so checkers can bind to the FSM state directly.
  state_e state;

  logic                 rx_meta;
  logic                 rxs;
  logic [PW-1:0]        phase;
  logic                 vote_a;
  logic                 vote_b;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 par_en_l;
  logic                 par_odd_l;
  logic                 stop2_l;
  logic                 stop_idx;
  logic                 stop_ferr;

  logic maj;
  logic last_stop;
  logic fe_now;
  logic pe_now;
  logic bd_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
    end
  end

  // The third vote is the live synchronised bit on the decision tick.
  always_comb begin
    maj       = (vote_a & vote_b) | (vote_a & rxs) | (vote_b & rxs);
    last_stop = !stop2_l || stop_idx;
    fe_now    = !maj || (stop_idx && stop_ferr);
    pe_now    = par_en_l && ((^shreg ^ par_bit) != par_odd_l);
    bd_now    = fe_now && (shreg == '0) && (!par_bit || !par_en_l);
  end

  // Output handshake: data_valid is a one-cycle strobe with no back-pressure;
  // rx_data and the three error flags are qualified by it and must be taken that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_IDLE;
      busy       <= 1'b1;
      phase      <= '0;
      vote_a     <= 1'b1;
      vote_b     <= 1'b1;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      par_en_l   <= 1'b0;
      par_odd_l  <= 1'b0;
      stop2_l    <= 1'b0;
      stop_idx   <= 1'b0;
      stop_ferr  <= 1'b0;
      rx_data    <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;

      if (sample_tick) begin
        if (phase == PH_A) vote_a <= rxs;
        if (phase == PH_B) vote_b <= rxs;
        if (state inside {START, DATA, PARITY, STOP})
          phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;

        case (state)
          WAIT_IDLE, BREAK_WAIT: begin
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          IDLE: begin
            // The tick that sees the falling edge counts as phase 0.
            if (!rxs) begin
              state <= START;
              busy  <= 1'b1;
              phase <= PH_ONE;
            end
          end

          START: begin
            if (phase == PH_DEC) begin
              if (maj) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state     <= DATA;
                bit_idx   <= '0;
                par_en_l  <= parity_en;
                par_odd_l <= parity_odd;
                stop2_l   <= stop2;
                par_bit   <= 1'b0;
                stop_idx  <= 1'b0;
                stop_ferr <= 1'b0;
              end
            end
          end

          DATA: begin
            if (phase == PH_DEC) begin
              shreg[bit_idx] <= maj;
              if (bit_idx == IDX_LAST)
                state <= par_en_l ? PARITY : STOP;
              else
                bit_idx <= bit_idx + 1'b1;
            end
          end

          PARITY: begin
            if (phase == PH_DEC) begin
              par_bit <= maj;
              state   <= STOP;
            end
          end

          STOP: begin
            if (phase == PH_DEC) begin
              if (!last_stop) begin
                stop_idx  <= 1'b1;
                stop_ferr <= !maj;
              end else begin
                rx_data    <= shreg;
                data_valid <= 1'b1;
                parity_err <= pe_now;
                frame_err  <= fe_now;
                break_det  <= bd_now;
                // Leaving at mid-stop leaves half a bit to catch the next start edge.
                if (bd_now) begin
                  state <= BREAK_WAIT;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end
            end
          end

          default: begin
            state <= WAIT_IDLE;
            busy  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: vector table of frames plus hand-written
// sequences for glitches, line break, back-to-back frames and mid-frame reset.
module tb_uart_rx_cfg;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rx8 = 1'b1;
  logic       rx7 = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       stop2 = 1'b0;

  logic [7:0] rd8;
  logic       dv8, pe8, fe8, bd8, busy8;
  logic [6:0] rd7;
  logic       dv7, pe7, fe7, bd7, busy7;

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16)) dut8 (
    .clk(clk), .rst(rst), .rx_in(rx8), .sample_tick(sample_tick),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .rx_data(rd8), .data_valid(dv8), .parity_err(pe8), .frame_err(fe8),
    .break_det(bd8), .busy(busy8)
  );

  uart_rx_cfg #(.DATA_BITS(7), .OVERSAMPLE(16)) dut7 (
    .clk(clk), .rst(rst), .rx_in(rx7), .sample_tick(sample_tick),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .rx_data(rd7), .data_valid(dv7), .parity_err(pe7), .frame_err(fe7),
    .break_det(bd7), .busy(busy7)
  );

  // Clock and tick generation: one sample_tick every 4 clocks.
  always #5 clk = ~clk;

  int tdiv = 0;
  always @(negedge clk) begin
    tdiv = (tdiv + 1) % 4;
    sample_tick = (tdiv == 0);
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard: records are {data[8:0], parity_err, frame_err, break_det}.
  logic [11:0] exp8_q[$];
  logic [11:0] act8_q[$];
  logic [11:0] exp7_q[$];
  logic [11:0] act7_q[$];
  int          t8_q[$];
  int          stray = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          start_cyc = 0;

  always @(negedge clk) begin
    if (dv8) begin
      act8_q.push_back({1'b0, rd8, pe8, fe8, bd8});
      t8_q.push_back(cyc);
    end else if (pe8 || fe8 || bd8) begin
      stray++;
    end
    if (dv7) act7_q.push_back({2'b00, rd7, pe7, fe7, bd7});
    else if (pe7 || fe7 || bd7) stray++;
  end

  typedef struct {
    bit         use7;
    logic [8:0] data;
    bit         pen;
    bit         podd;
    bit         s2;
    bit         pbit;
    bit         sa;
    bit         sb;
    bit         flip;
    logic [8:0] exp_data;
    bit         exp_pe;
    bit         exp_fe;
    bit         exp_bd;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    @(posedge clk);
    while (!sample_tick) @(posedge clk);
    #1;
  endtask

  task automatic drive_ticks(input bit w, input logic v, input int n);
    if (w) rx7 = v;
    else rx8 = v;
    repeat (n) wait_tick();
  endtask

  // Drives one frame on the selected line; 16 ticks per bit, starting right after a tick.
  task automatic send_frame(input bit w, input logic [8:0] d, input int nb, input bit pen,
                            input bit podd, input bit s2, input bit pbit, input bit sa,
                            input bit sb, input bit flip);
    parity_en  = pen;
    parity_odd = podd;
    stop2      = s2;
    if (!w) begin
      t8_q.delete();
      start_cyc = cyc;
    end
    drive_ticks(w, 1'b0, 16);
    if (flip) begin
      parity_en  = !pen;
      parity_odd = !podd;
      stop2      = !s2;
    end
    for (int i = 0; i < nb; i++) drive_ticks(w, d[i], 16);
    if (pen) drive_ticks(w, pbit, 16);
    drive_ticks(w, sa, 16);
    if (s2) drive_ticks(w, sb, 16);
  endtask

  task automatic check_frames(input bit w, input string name);
    logic [11:0] a;
    logic [11:0] e;
    if (!w) begin
      chk({name, " count"}, act8_q.size(), exp8_q.size());
      while (act8_q.size() > 0 && exp8_q.size() > 0) begin
        a = act8_q.pop_front();
        e = exp8_q.pop_front();
        chk({name, " frame"}, a, e);
      end
      act8_q.delete();
      exp8_q.delete();
    end else begin
      chk({name, " count"}, act7_q.size(), exp7_q.size());
      while (act7_q.size() > 0 && exp7_q.size() > 0) begin
        a = act7_q.pop_front();
        e = exp7_q.pop_front();
        chk({name, " frame"}, a, e);
      end
      act7_q.delete();
      exp7_q.delete();
    end
  endtask

  function automatic vec_t mk(input bit use7, input logic [8:0] d, input bit pen, input bit podd,
                              input bit s2, input bit pbit, input bit sa, input bit sb,
                              input bit flip, input logic [8:0] ed, input bit epe,
                              input bit efe, input bit ebd);
    vec_t v;
    v.use7 = use7; v.data = d; v.pen = pen; v.podd = podd; v.s2 = s2;
    v.pbit = pbit; v.sa = sa; v.sb = sb; v.flip = flip;
    v.exp_data = ed; v.exp_pe = epe; v.exp_fe = efe; v.exp_bd = ebd;
    return v;
  endfunction

  initial begin
    //            dut7 data     pen podd s2 pbit sa sb flip  exp    pe fe bd
    vecs[0]  = mk(N, 9'h0A5, N, N, N, N, Y, Y, N, 9'h0A5, N, N, N);
    vecs[1]  = mk(N, 9'h007, Y, N, N, N, Y, Y, N, 9'h007, Y, N, N);
    vecs[2]  = mk(N, 9'h007, Y, N, N, Y, Y, Y, N, 9'h007, N, N, N);
    vecs[3]  = mk(N, 9'h03C, Y, Y, N, Y, Y, Y, N, 9'h03C, N, N, N);
    vecs[4]  = mk(N, 9'h0FF, N, N, Y, N, Y, Y, N, 9'h0FF, N, N, N);
    vecs[5]  = mk(N, 9'h055, N, N, N, N, N, Y, N, 9'h055, N, Y, N);
    vecs[6]  = mk(N, 9'h000, N, N, N, N, N, Y, N, 9'h000, N, Y, Y);
    vecs[7]  = mk(N, 9'h000, Y, N, N, Y, N, Y, N, 9'h000, Y, Y, N);
    vecs[8]  = mk(N, 9'h080, Y, N, Y, Y, Y, N, N, 9'h080, N, Y, N);
    vecs[9]  = mk(N, 9'h007, Y, N, N, N, Y, Y, Y, 9'h007, Y, N, N);
    vecs[10] = mk(Y, 9'h02B, Y, Y, Y, Y, Y, N, N, 9'h02B, N, Y, N);

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    chk("reset busy8", busy8, 1);
    chk("reset busy7", busy7, 1);
    chk("reset dv8", dv8, 0);
    chk("reset rx_data8", rd8, 0);
    rst = 1'b0;
    wait_tick();
    drive_ticks(N, 1'b1, 4);
    chk("idle busy8", busy8, 0);
    chk("idle busy7", busy7, 0);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].use7)
        exp7_q.push_back({vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].exp_bd});
      else
        exp8_q.push_back({vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].exp_bd});
      send_frame(vecs[i].use7, vecs[i].data, vecs[i].use7 ? 7 : 8, vecs[i].pen, vecs[i].podd,
                 vecs[i].s2, vecs[i].pbit, vecs[i].sa, vecs[i].sb, vecs[i].flip);
      // The edge lands just after a tick and is seen as phase 0 on the next tick;
      // the stop decision is phase 9 of bit 9: (1 + 9*16 + 9) ticks * 4 clks = 616.
      if (i == 0) chk("latency 0xA5", (t8_q.size() > 0) ? t8_q[0] - start_cyc : -1, 616);
      drive_ticks(vecs[i].use7, 1'b1, 32);
      check_frames(vecs[i].use7, $sformatf("vec%0d", i));
    end

    // Back-to-back 7O2 frames with no idle gap
    exp7_q.push_back({9'h011, 3'b000});
    exp7_q.push_back({9'h06E, 3'b000});
    send_frame(Y, 9'h011, 7, Y, Y, Y, Y, Y, Y, N);
    send_frame(Y, 9'h06E, 7, Y, Y, Y, N, Y, Y, N);
    drive_ticks(Y, 1'b1, 32);
    check_frames(Y, "b2b");

    // Short low glitch: false start, no output
    drive_ticks(N, 1'b0, 4);
    drive_ticks(N, 1'b1, 40);
    check_frames(N, "false start");
    chk("false start busy", busy8, 0);

    // 0x00 with a one-tick high glitch at phase 8 of data bit 3
    exp8_q.push_back({9'h000, 3'b000});
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    drive_ticks(N, 1'b0, 72);
    drive_ticks(N, 1'b1, 1);
    drive_ticks(N, 1'b0, 71);
    drive_ticks(N, 1'b1, 48);
    check_frames(N, "vote glitch");

    // Line break: 12 bit periods low
    exp8_q.push_back({9'h000, 3'b011});
    drive_ticks(N, 1'b0, 192);
    check_frames(N, "break");
    chk("break busy", busy8, 1);
    drive_ticks(N, 1'b1, 160);
    check_frames(N, "after break");
    exp8_q.push_back({9'h03C, 3'b000});
    send_frame(N, 9'h03C, 8, N, N, N, N, Y, Y, N);
    drive_ticks(N, 1'b1, 32);
    check_frames(N, "post-break 0x3C");

    // Reset during data bit 4 of 0x6F (line low at that point)
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    drive_ticks(N, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive_ticks(N, 1'b1, 16);
    drive_ticks(N, 1'b0, 8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid reset busy", busy8, 1);
    chk("mid reset rx_data", rd8, 0);
    drive_ticks(N, 1'b0, 40);
    chk("stuck low busy", busy8, 1);
    check_frames(N, "aborted frame");
    drive_ticks(N, 1'b1, 32);
    chk("released busy", busy8, 0);
    exp8_q.push_back({9'h05A, 3'b000});
    send_frame(N, 9'h05A, 8, N, N, N, N, Y, Y, N);
    drive_ticks(N, 1'b1, 32);
    check_frames(N, "post-reset 0x5A");

    chk("stray error pulses", stray, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
